// File: rtl/slave_access_arbiter_pkg.sv
// Shared definitions for the slave access arbiter: select encodings, FSM state
// type, SRAM idle constant and the IDLE-rule grant picker.
package slave_access_arbiter_pkg;

  localparam logic [1:0] SEL_IDLE  = 2'b00;
  localparam logic [1:0] SEL_READ  = 2'b01;
  localparam logic [1:0] SEL_WRITE = 2'b10;
  localparam logic [3:0] WEB_NONE  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = SEL_IDLE,
    ST_READ  = SEL_READ,
    ST_WRITE = SEL_WRITE
  } state_t;

  // Ties go to the type not granted most recently (last_grant: 1 = write).
  function automatic state_t pick_grant(input logic arvalid, input logic awvalid,
                                        input logic last_grant);
    state_t grant;
    if (arvalid && awvalid) begin
      grant = last_grant ? ST_READ : ST_WRITE;
    end else if (arvalid) begin
      grant = ST_READ;
    end else if (awvalid) begin
      grant = ST_WRITE;
    end else begin
      grant = ST_IDLE;
    end
    return grant;
  endfunction

endpackage

// File: rtl/slave_access_arbiter.sv
// Arbitrates the single SRAM port between the AXI read and write slave engines.
// Optional grant timeout is built when SLAVE_ARB_TIMEOUT_EN is defined.
module slave_access_arbiter
  import slave_access_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 14,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ARVALID,
  input  logic              AWVALID,
  input  logic              read_finish,
  input  logic              write_finish,
  output logic [1:0]        select,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_web,
  input  logic [DATA_W-1:0] wr_data,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic [3:0]        sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_di,
  output logic              timeout_err
);

  state_t state;
  state_t next_state;
  logic   last_grant;
  logic   release_now;
  logic   grant_entry;
  logic   timeout_hit;

  // State register and most-recent grant type
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= next_state;
      if (grant_entry) begin
        last_grant <= (next_state == ST_WRITE);
      end
    end
  end

  // Current grant is released (or absent) this cycle; opposite finish is ignored
  always_comb begin
    case (state)
      ST_IDLE:  release_now = 1'b1;
      ST_READ:  release_now = read_finish;
      ST_WRITE: release_now = write_finish;
      default:  release_now = 1'b1;
    endcase
  end

  // Next-state: a release re-arbitrates immediately so back-to-back grants have no bubble
  always_comb begin
    next_state  = state;
    grant_entry = 1'b0;
    if (release_now) begin
      next_state  = pick_grant(ARVALID, AWVALID, last_grant);
      grant_entry = (next_state != ST_IDLE);
    end else if (timeout_hit) begin
      next_state = ST_IDLE;
    end else begin
      next_state = state;
    end
  end

`ifdef SLAVE_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_pulse;

  assign timeout_hit = (state != ST_IDLE) && !release_now &&
                       (hold_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_pulse;

  // Grant age counter and one-cycle revoke pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cnt      <= {CNT_W{1'b0}};
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= timeout_hit;
      if (grant_entry || (state == ST_IDLE)) begin
        hold_cnt <= {CNT_W{1'b0}};
      end else begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign select = state;

  // SRAM mux: zero-latency pass-through of the granted engine; write enables only in WRITE
  always_comb begin
    sram_cs  = 1'b0;
    sram_oe  = 1'b0;
    sram_web = WEB_NONE;
    sram_a   = {ADDR_W{1'b0}};
    sram_di  = {DATA_W{1'b0}};
    case (state)
      ST_READ: begin
        sram_cs = 1'b1;
        sram_oe = rd_en;
        sram_a  = rd_addr;
      end
      ST_WRITE: begin
        sram_cs  = 1'b1;
        sram_web = wr_web;
        sram_a   = wr_addr;
        sram_di  = wr_data;
      end
      default: begin
        sram_cs  = 1'b0;
        sram_web = WEB_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_slave_access_arbiter.sv
// Self-checking bench for slave_access_arbiter: directed scenarios plus random
// stimulus against a grant-level reference model.
module tb_slave_access_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int TO     = 8;
  localparam int BUS_W  = 9 + ADDR_W + DATA_W;
`ifdef SLAVE_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              ARVALID, AWVALID, read_finish, write_finish, rd_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [3:0]        wr_web;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        select;
  logic              sram_cs, sram_oe, timeout_err;
  logic [3:0]        sram_web;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_di;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0 = nobody holds the SRAM, 1 = reader, 2 = writer
  int m_state;
  bit m_last_w;
  int m_age;
  bit m_terr;

  always #5 clock = ~clock;

  slave_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .ARVALID(ARVALID), .AWVALID(AWVALID),
    .read_finish(read_finish), .write_finish(write_finish), .select(select),
    .rd_addr(rd_addr), .rd_en(rd_en), .wr_addr(wr_addr), .wr_web(wr_web),
    .wr_data(wr_data), .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web),
    .sram_a(sram_a), .sram_di(sram_di), .timeout_err(timeout_err)
  );

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_inputs();
    ARVALID = 1'b0; AWVALID = 1'b0; read_finish = 1'b0; write_finish = 1'b0;
    rd_en = 1'b0; rd_addr = '0; wr_addr = '0; wr_web = 4'hF; wr_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic int pick(bit ar, bit aw, bit last_w);
    if (ar && aw) return last_w ? 1 : 2;
    if (ar) return 1;
    if (aw) return 2;
    return 0;
  endfunction

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    bit done;
    int nxt;
    if (reset) begin
      m_state = 0; m_last_w = 1'b1; m_age = 0; m_terr = 1'b0;
    end else begin
      m_terr = 1'b0;
      done = (m_state == 0) || (m_state == 1 && read_finish) || (m_state == 2 && write_finish);
      if (done) begin
        nxt = pick(ARVALID, AWVALID, m_last_w);
        if (nxt != 0) begin
          m_last_w = (nxt == 2);
          m_age = 0;
        end
      end else if (TO_EN && m_age == TO - 1) begin
        nxt = 0;
        m_terr = 1'b1;
      end else begin
        nxt = m_state;
        m_age++;
      end
      m_state = nxt;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (select !== 2'b00) begin n_fail++; $display("FAIL reset_select: got %b expected 00", select); end
    n_checks++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    n_checks++;
    if ({sram_cs, sram_oe, sram_web, sram_a, sram_di} !== {1'b0, 1'b0, 4'hF, {ADDR_W{1'b0}}, {DATA_W{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_sram: got cs=%b oe=%b web=%h a=%h di=%h expected 0 0 f 0 0",
               sram_cs, sram_oe, sram_web, sram_a, sram_di);
    end
  endtask

  task automatic test_read_grant();
    do_reset();
    ARVALID = 1'b1; rd_addr = 14'h0010; rd_en = 1'b1;
    tick();
    ARVALID = 1'b0;
    #1;
    n_checks++;
    if (select !== 2'b01) begin n_fail++; $display("FAIL read_grant_select: got %b expected 01", select); end
    n_checks++;
    if ({sram_cs, sram_oe, sram_web, sram_a, sram_di} !== {1'b1, 1'b1, 4'hF, 14'h0010, 32'h0}) begin
      n_fail++;
      $display("FAIL read_grant_sram: got cs=%b oe=%b web=%h a=%h di=%h expected 1 1 f 0010 0",
               sram_cs, sram_oe, sram_web, sram_a, sram_di);
    end
    rd_en = 1'b0;
    #1;
    n_checks++;
    if (sram_oe !== 1'b0) begin n_fail++; $display("FAIL read_oe_follows_rd_en: got %b expected 0", sram_oe); end
    read_finish = 1'b1;
    tick();
    read_finish = 1'b0;
    n_checks++;
    if (select !== 2'b00) begin n_fail++; $display("FAIL read_release: got %b expected 00", select); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    do_reset();
    ARVALID = 1'b1; AWVALID = 1'b1;
    tick();
    for (int g = 0; g < 4; g++) begin
      exp = (g % 2 == 0) ? 2'b01 : 2'b10;
      for (int c = 1; c <= 3; c++) begin
        n_checks++;
        if (select !== exp) begin
          n_fail++;
          $display("FAIL rr_grant%0d_cycle%0d: got %b expected %b", g, c, select, exp);
        end
        if (c < 3) tick();
      end
      if (exp == 2'b01) read_finish = 1'b1; else write_finish = 1'b1;
      if (g == 3) begin ARVALID = 1'b0; AWVALID = 1'b0; end
      tick();
      read_finish = 1'b0; write_finish = 1'b0;
    end
    n_checks++;
    if (select !== 2'b00) begin n_fail++; $display("FAIL rr_final_idle: got %b expected 00", select); end
  endtask

  task automatic test_write_hold();
    do_reset();
    AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    n_checks++;
    if (select !== 2'b10) begin n_fail++; $display("FAIL write_grant_select: got %b expected 10", select); end
    wr_web = 4'b1100; wr_data = 32'hDEADBEEF; wr_addr = 14'h1234; read_finish = 1'b1;
    tick();
    read_finish = 1'b0;
    #1;
    n_checks++;
    if (select !== 2'b10) begin n_fail++; $display("FAIL write_ignores_read_finish: got %b expected 10", select); end
    n_checks++;
    if ({sram_cs, sram_oe, sram_web, sram_a, sram_di} !== {1'b1, 1'b0, 4'b1100, 14'h1234, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL write_sram: got cs=%b oe=%b web=%b a=%h di=%h expected 1 0 1100 1234 deadbeef",
               sram_cs, sram_oe, sram_web, sram_a, sram_di);
    end
    write_finish = 1'b1;
    tick();
    write_finish = 1'b0;
    #1;
    n_checks++;
    if (select !== 2'b00 || sram_web !== 4'hF) begin
      n_fail++;
      $display("FAIL write_release: got sel=%b web=%h expected 00 f", select, sram_web);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    n_checks++;
    if (select !== 2'b01) begin n_fail++; $display("FAIL midreset_grant: got %b expected 01", select); end
    reset = 1'b1; read_finish = 1'b1; AWVALID = 1'b1;
    tick();
    reset = 1'b0; read_finish = 1'b0;
    #1;
    n_checks++;
    if ({select, sram_cs, sram_web} !== {2'b00, 1'b0, 4'hF}) begin
      n_fail++;
      $display("FAIL midreset_idle: got sel=%b cs=%b web=%h expected 00 0 f", select, sram_cs, sram_web);
    end
    tick();
    AWVALID = 1'b0;
    n_checks++;
    if (select !== 2'b10) begin n_fail++; $display("FAIL midreset_then_write: got %b expected 10", select); end
    write_finish = 1'b1;
    tick();
    write_finish = 1'b0;
  endtask

`ifdef SLAVE_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    for (int c = 1; c <= TO; c++) begin
      n_checks++;
      if (select !== 2'b01 || timeout_err !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_hold_cycle%0d: got sel=%b err=%b expected 01 0", c, select, timeout_err);
      end
      tick();
    end
    n_checks++;
    if (select !== 2'b00 || timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_revoke: got sel=%b err=%b expected 00 1", select, timeout_err);
    end
    ARVALID = 1'b1; AWVALID = 1'b1;
    tick();
    ARVALID = 1'b0; AWVALID = 1'b0;
    n_checks++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse_width: got %b expected 0", timeout_err); end
    n_checks++;
    if (select !== 2'b10) begin n_fail++; $display("FAIL timeout_tie_to_write: got %b expected 10", select); end
    write_finish = 1'b1;
    tick();
    write_finish = 1'b0;
  endtask
`else
  task automatic test_long_hold();
    do_reset();
    ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      n_checks++;
      if (select !== 2'b01 || timeout_err !== 1'b0) begin
        n_fail++;
        $display("FAIL long_hold_cycle%0d: got sel=%b err=%b expected 01 0", c, select, timeout_err);
      end
      tick();
    end
    read_finish = 1'b1;
    tick();
    read_finish = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [BUS_W-1:0] exp_bus;
    logic [BUS_W-1:0] got_bus;
    do_reset();
    m_state = 0; m_last_w = 1'b1; m_age = 0; m_terr = 1'b0;
    for (int i = 0; i < 800; i++) begin
      reset        = ($urandom_range(0, 63) == 0);
      ARVALID      = 1'($urandom_range(0, 1));
      AWVALID      = 1'($urandom_range(0, 1));
      read_finish  = ($urandom_range(0, 4) == 0);
      write_finish = ($urandom_range(0, 4) == 0);
      rd_en        = 1'($urandom_range(0, 1));
      rd_addr      = ADDR_W'($urandom);
      wr_addr      = ADDR_W'($urandom);
      wr_web       = 4'($urandom);
      wr_data      = $urandom;
      #1;
      case (m_state)
        1:       exp_bus = {2'b01, m_terr, 1'b1, rd_en, 4'hF, rd_addr, {DATA_W{1'b0}}};
        2:       exp_bus = {2'b10, m_terr, 1'b1, 1'b0, wr_web, wr_addr, wr_data};
        default: exp_bus = {2'b00, m_terr, 1'b0, 1'b0, 4'hF, {ADDR_W{1'b0}}, {DATA_W{1'b0}}};
      endcase
      got_bus = {select, timeout_err, sram_cs, sram_oe, sram_web, sram_a, sram_di};
      n_checks++;
      if (got_bus !== exp_bus) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %h expected %h", i, got_bus, exp_bus);
      end
      model_step();
      tick();
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_read_grant();
    test_round_robin();
    test_write_hold();
    test_reset_mid_grant();
`ifdef SLAVE_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_long_hold();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/slave_access_arbiter.md
SLAVE_ACCESS_ARBITER -- requirements
Module: slave_access_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, SRAM data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, maximum cycles one grant may be held (used only with the timeout feature).
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports ARVALID / AWVALID, input, 1 each, pending read / write address requests from the AXI slave channels.
REQ-007 SHALL have ports read_finish / write_finish, input, 1 each, one-cycle completion pulses from the read / write slave engines.
REQ-008 SHALL have port select, output, 2, grant to the slave engines: SEL_IDLE=2'b00, SEL_READ=2'b01, SEL_WRITE=2'b10.
REQ-009 SHALL have ports rd_addr (in, ADDR_W) and rd_en (in, 1), the read engine's SRAM request.
REQ-010 SHALL have ports wr_addr (in, ADDR_W), wr_web (in, 4, active-low byte write enables) and wr_data (in, DATA_W), the write engine's SRAM request.
REQ-011 SHALL have ports sram_cs (out, 1), sram_oe (out, 1), sram_web (out, 4), sram_a (out, ADDR_W) and sram_di (out, DATA_W), the shared SRAM port.
REQ-012 SHALL have port timeout_err, output, 1, one-cycle pulse when a grant is revoked by timeout.

Function
REQ-013 SHALL implement a registered FSM with states IDLE, READ, WRITE; select SHALL equal the state encoding and depend only on registered state.
REQ-014 In IDLE with only ARVALID high, next state SHALL be READ; with only AWVALID high, WRITE; with neither, IDLE.
REQ-015 In IDLE with ARVALID and AWVALID both high, the grant SHALL go to the type not granted most recently (register last_grant, 1 = write); after reset, read wins the first tie.
REQ-016 In READ, the state SHALL hold until read_finish=1; write_finish is ignored in READ.
REQ-017 In WRITE, the state SHALL hold until write_finish=1; read_finish is ignored in WRITE.
REQ-018 On the finish cycle, next state SHALL be chosen by the IDLE rules of REQ-014/015 using the updated last_grant, giving a back-to-back grant with no IDLE bubble.
REQ-019 last_grant SHALL update on each entry into READ (0) or WRITE (1).
REQ-020 In READ: sram_cs=1, sram_oe=rd_en, sram_web=4'hF, sram_a=rd_addr, sram_di=0 (combinational pass-through, zero latency).
REQ-021 In WRITE: sram_cs=1, sram_oe=0, sram_web=wr_web, sram_a=wr_addr, sram_di=wr_data.
REQ-022 In IDLE: sram_cs=0, sram_oe=0, sram_web=4'hF, sram_a=0, sram_di=0.
REQ-023 The SRAM port SHALL never see a write enable (any sram_web bit 0) while state is not WRITE.

Reset
REQ-024 While reset=1 at a clock edge: state=IDLE, last_grant=1 (read wins next tie), timeout counter=0, timeout_err=0.
REQ-025 Reset asserted mid-grant SHALL return to IDLE on that edge regardless of pending finish or valid inputs; all outputs take IDLE values the following cycle.

Configuration
REQ-026 With macro SLAVE_ARB_TIMEOUT_EN defined: a counter SHALL clear on every grant entry, increment each cycle in READ/WRITE, and on reaching TIMEOUT_CYCLES-1 without finish force next state IDLE and pulse timeout_err for one cycle; last_grant keeps the revoked type so the other type wins the next tie.
REQ-027 Without SLAVE_ARB_TIMEOUT_EN: no counter SHALL be built, timeout_err SHALL be tied to 0, and grants are held indefinitely.

Structure
REQ-028 A shared package SHALL hold the select encodings (SEL_IDLE, SEL_READ, SEL_WRITE), the FSM state typedef and the WEB_NONE=4'hF constant.
REQ-029 The design SHALL be one module with no sub-modules; the SRAM mux is inline combinational logic.

Verification
REQ-030 Reset, then ARVALID=1 only -> select=2'b01 next cycle; rd_addr=14'h0010, rd_en=1 -> sram_a=14'h0010, sram_oe=1, sram_web=4'hF.
REQ-031 ARVALID=AWVALID=1 held, finish pulses 3 cycles after each grant -> grants READ, WRITE, READ, WRITE with no IDLE cycle between them.
REQ-032 In WRITE with wr_web=4'b1100, wr_data=32'hDEADBEEF, read_finish pulsed -> state stays WRITE, sram_web=4'b1100, sram_di=32'hDEADBEEF.
REQ-033 reset=1 during READ with simultaneous read_finish and AWVALID -> select=2'b00 next cycle; after release, AWVALID alone -> WRITE.
REQ-034 With SLAVE_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, grant READ and never finish -> IDLE after 8 grant cycles, timeout_err high exactly 1 cycle; a following tie grants WRITE.
REQ-035 Without SLAVE_ARB_TIMEOUT_EN, READ held 1000 cycles -> select stays 2'b01, timeout_err stays 0.
